// File: rtl/axi_common_types_pkg.sv
// ---------------------------------------------------------------------------
// axi_common_types_pkg
// Shared AXI NoC constants and types used by the slave-port write arbiters.
// ---------------------------------------------------------------------------
package axi_common_types_pkg;

    localparam int unsigned AXI_ID_WIDTH    = 4;
    localparam int unsigned NOC_NUM_MASTERS = 4;
    localparam int unsigned NOC_MIDX_WIDTH  = 2;
    localparam int unsigned NOC_MAX_OUTST   = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } wr_arb_state_e;

endpackage : axi_common_types_pkg

// File: rtl/s5_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// s5_wr_arbiter_if
// Handshake/select bundle between the masters, slave S5 and the write arbiter.
// modport master : arbiter side (drives readys, S5 valids, mux selects)
// modport slave  : environment side (masters + S5 + payload muxes)
// Signals: m_awvalid/m_awready, S5_AWVALID/S5_AWREADY, aw_sel,
//          m_wvalid/m_wlast/m_wready, S5_WVALID/S5_WREADY, w_sel,
//          S5_BVALID/S5_BID/S5_BREADY, m_bvalid/m_bready.
// ---------------------------------------------------------------------------
interface s5_wr_arbiter_if
    import axi_common_types_pkg::*;
#(
    parameter int unsigned NUM_M = NOC_NUM_MASTERS,
    parameter int unsigned ID_W  = AXI_ID_WIDTH
) ();

    localparam int unsigned MIDX_W = $clog2(NUM_M);

    logic [NUM_M-1:0]  m_awvalid;
    logic [NUM_M-1:0]  m_awready;
    logic              S5_AWVALID;
    logic              S5_AWREADY;
    logic [MIDX_W-1:0] aw_sel;

    logic [NUM_M-1:0]  m_wvalid;
    logic [NUM_M-1:0]  m_wlast;
    logic [NUM_M-1:0]  m_wready;
    logic              S5_WVALID;
    logic              S5_WREADY;
    logic [MIDX_W-1:0] w_sel;

    logic              S5_BVALID;
    logic [ID_W-1:0]   S5_BID;
    logic              S5_BREADY;
    logic [NUM_M-1:0]  m_bvalid;
    logic [NUM_M-1:0]  m_bready;

    modport master (
        input  m_awvalid, S5_AWREADY, m_wvalid, m_wlast, S5_WREADY,
               S5_BVALID, S5_BID, m_bready,
        output m_awready, S5_AWVALID, aw_sel, m_wready, S5_WVALID, w_sel,
               S5_BREADY, m_bvalid
    );

    modport slave (
        output m_awvalid, S5_AWREADY, m_wvalid, m_wlast, S5_WREADY,
               S5_BVALID, S5_BID, m_bready,
        input  m_awready, S5_AWVALID, aw_sel, m_wready, S5_WVALID, w_sel,
               S5_BREADY, m_bvalid
    );

endinterface : s5_wr_arbiter_if

// File: rtl/noc_idx_fifo.sv
// ---------------------------------------------------------------------------
// noc_idx_fifo
// Synchronous FIFO of master indices recording AW grant order for W steering.
// Ports: clk, rst (async, active-high), i_push/i_din, i_pop,
//        o_head (0 when empty), o_full, o_empty.
// ---------------------------------------------------------------------------
module noc_idx_fifo #(
    parameter int unsigned W     = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A push into a full FIFO is only taken when a pop frees a slot this cycle
    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only read while counted valid
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule : noc_idx_fifo

// File: rtl/s5_wr_arbiter.sv
// ---------------------------------------------------------------------------
// s5_wr_arbiter
// Write-path controller for NoC slave port S5: round-robin AW arbitration,
// W steering in AW-grant order until WLAST, B routing by master index in BID.
// Ports: ACLK, ARESET (async, active-high), bus (s5_wr_arbiter_if.master).
// Only selects and valid/ready gating are produced; payload muxes are external.
// ---------------------------------------------------------------------------
module s5_wr_arbiter
    import axi_common_types_pkg::*;
#(
    parameter int unsigned NUM_M     = NOC_NUM_MASTERS,
    parameter int unsigned ID_W      = AXI_ID_WIDTH,
    parameter int unsigned MAX_OUTST = NOC_MAX_OUTST
) (
    input logic             ACLK,
    input logic             ARESET,
    s5_wr_arbiter_if.master bus
);

    localparam int unsigned MIDX_W = $clog2(NUM_M);

    wr_arb_state_e     r_state;
    wr_arb_state_e     w_state_nxt;
    logic [MIDX_W-1:0] r_aw_sel;
    logic [MIDX_W-1:0] w_aw_sel_nxt;
    logic [MIDX_W-1:0] r_rr_ptr;
    logic [MIDX_W-1:0] w_rr_ptr_nxt;

    logic [NUM_M-1:0]  w_m_awready;
    logic [NUM_M-1:0]  w_m_wready;
    logic [NUM_M-1:0]  w_m_bvalid;
    logic              w_awvalid;
    logic              w_wvalid;
    logic              w_bready;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [MIDX_W-1:0] w_head;
    logic [MIDX_W-1:0] w_bidx;

    // Round-robin pick: first requester scanning upward from ptr+1, wrapping
    function automatic logic [MIDX_W-1:0] rr_pick(input logic [NUM_M-1:0]  req,
                                                  input logic [MIDX_W-1:0] ptr);
        logic [MIDX_W-1:0] idx;
        logic [MIDX_W-1:0] win;
        logic              found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_M; i++) begin
            idx = ptr + MIDX_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    // AW FSM state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state  <= ARB_IDLE;
            r_aw_sel <= '0;
            r_rr_ptr <= MIDX_W'(NUM_M - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_aw_sel <= w_aw_sel_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // AW FSM next state and outputs; a grant is held until its handshake
    always_comb begin
        w_state_nxt  = r_state;
        w_aw_sel_nxt = r_aw_sel;
        w_rr_ptr_nxt = r_rr_ptr;
        w_awvalid    = 1'b0;
        w_m_awready  = '0;
        w_push       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if ((|bus.m_awvalid) && !w_fifo_full) begin
                    w_aw_sel_nxt = rr_pick(bus.m_awvalid, r_rr_ptr);
                    w_state_nxt  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                w_awvalid             = 1'b1;
                w_m_awready[r_aw_sel] = bus.S5_AWREADY;
                if (bus.S5_AWREADY) begin
                    w_push       = 1'b1;
                    w_rr_ptr_nxt = r_aw_sel;
                    w_state_nxt  = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    noc_idx_fifo #(
        .W     (MIDX_W),
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk     (ACLK),
        .rst     (ARESET),
        .i_push  (w_push),
        .i_din   (r_aw_sel),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // W steering from the FIFO head; nothing passes ahead of its AW
    always_comb begin
        w_wvalid   = 1'b0;
        w_m_wready = '0;
        if (!w_fifo_empty) begin
            w_wvalid           = bus.m_wvalid[w_head];
            w_m_wready[w_head] = bus.S5_WREADY;
        end
    end

    assign w_pop = !w_fifo_empty && bus.m_wvalid[w_head] && bus.S5_WREADY
                   && bus.m_wlast[w_head];

    // B routing by the master index in the top bits of BID
    assign w_bidx     = bus.S5_BID[ID_W-1 -: MIDX_W];
    assign w_m_bvalid = bus.S5_BVALID ? (NUM_M'(1) << w_bidx) : '0;
    assign w_bready   = bus.S5_BVALID && bus.m_bready[w_bidx];

    // Low BID bits carry the master's own transaction ID and are not decoded
    if (ID_W > MIDX_W) begin : g_bid_lo
        logic w_unused_bid_lo;
        assign w_unused_bid_lo = ^bus.S5_BID[ID_W-MIDX_W-1:0];
    end

    assign bus.S5_AWVALID = w_awvalid;
    assign bus.m_awready  = w_m_awready;
    assign bus.aw_sel     = r_aw_sel;
    assign bus.S5_WVALID  = w_wvalid;
    assign bus.m_wready   = w_m_wready;
    assign bus.w_sel      = w_head;
    assign bus.m_bvalid   = w_m_bvalid;
    assign bus.S5_BREADY  = w_bready;

endmodule : s5_wr_arbiter

// File: doc/s5_wr_arbiter.md
# s5_wr_arbiter

Write-path controller for slave port S5 of the 4-master/7-slave AXI NoC. Shares S5's AW channel among the masters with round-robin arbitration. Steers the W channel in AW-grant order until WLAST. Routes B responses back to the issuing master by the master index carried in BID. Drives mux selects and per-master valid/ready gating only; the payload muxes sit outside the block.

## Interface
- NUM_M, 4: number of masters; power of two, at least 2.
- ID_W, 4: BID width; equals AXI_ID_WIDTH. BID[ID_W-1 -: MIDX_W] holds the master index.
- MAX_OUTST, 4: depth of the W-order FIFO, i.e. the number of AW grants whose data is not yet complete.
- Derived: MIDX_W = $clog2(NUM_M).
- ACLK  in  1  clock; everything is sampled on posedge.
- ARESET  in  1  asynchronous, active-high reset.
- m_awvalid  in  NUM_M  per-master AW request.
- m_awready  out  NUM_M  per-master AW ready.
- S5_AWVALID  out  1  AW valid to S5.
- S5_AWREADY  in  1  AW ready from S5.
- aw_sel  out  MIDX_W  AW payload mux select.
- m_wvalid  in  NUM_M  per-master W valid.
- m_wlast  in  NUM_M  per-master WLAST.
- m_wready  out  NUM_M  per-master W ready.
- S5_WVALID  out  1  W valid to S5.
- S5_WREADY  in  1  W ready from S5.
- w_sel  out  MIDX_W  W payload mux select; equals the FIFO head.
- S5_BVALID  in  1  B valid from S5.
- S5_BID  in  ID_W  B ID from S5.
- S5_BREADY  out  1  B ready to S5.
- m_bvalid  out  NUM_M  per-master B valid.
- m_bready  in  NUM_M  per-master B ready.

## Operation
- AW FSM, two states:
  - IDLE: if any m_awvalid is set and the FIFO is not full, pick the winner round-robin, scanning from rr_ptr+1 upward and wrapping. Register the winner into aw_sel and go to GRANT.
  - GRANT: S5_AWVALID=1. m_awready[aw_sel]=S5_AWREADY; every other m_awready bit is 0.
  - On the AW handshake (S5_AWVALID & S5_AWREADY): push aw_sel into the FIFO, set rr_ptr<=aw_sel, return to IDLE.
- A grant is never revoked before its handshake, even if the master drops m_awvalid.
- W steering: w_sel = FIFO head.
  - FIFO non-empty: S5_WVALID = m_wvalid[head]; m_wready[head] = S5_WREADY; all other m_wready bits are 0.
  - FIFO empty: S5_WVALID = 0 and m_wready = 0. W data is never accepted ahead of its AW.
  - A W handshake with m_wlast[head]=1 pops the FIFO.
- B routing is combinational, with idx = S5_BID[ID_W-1 -: MIDX_W]:
  - m_bvalid = S5_BVALID ? (1<<idx) : 0.
  - S5_BREADY = m_bready[idx].
- FIFO occupancy counter is $clog2(MAX_OUTST+1) bits wide. Pointers wrap modulo MAX_OUTST.

## Timing
- Reset (asynchronous, on ARESET=1):
  - FSM goes to IDLE, rr_ptr=NUM_M-1 (master 0 gets first priority), FIFO empty.
  - S5_AWVALID=0, aw_sel=0, m_awready=0, S5_WVALID=0, m_wready=0, w_sel=0.
  - B outputs are 0 whenever S5_BVALID=0.
- AW latency: a request sampled at edge N gives S5_AWVALID=1 after edge N (in the N+1 cycle).
  - Handshake at edge N+1 returns the FSM to IDLE. The next grant is visible after edge N+2, so there is one bubble per AW.
  - Best-case throughput is one AW per 2 cycles.
- W latency: after an AW handshake at edge K, the first W handshake can happen at edge K+1 at the earliest, because the push is visible after K.
- Simultaneous push and pop in the same cycle: occupancy is unchanged. This is legal even when the FIFO is full, since full blocks only IDLE→GRANT.
- FIFO full: the FSM stays in IDLE and requests wait. Occupancy never exceeds MAX_OUTST.
- Single-beat burst (WLAST on the first beat): pops on that beat.
- Reset mid-burst: all outstanding grants are dropped. After ARESET deasserts, outputs hold their reset values until the first new arbitration.

## Structure
- In axi_common_types_pkg:
  - NOC_NUM_MASTERS=4, NOC_MIDX_WIDTH=2.
  - typedef enum logic {ARB_IDLE, ARB_GRANT} wr_arb_state_e.
- The block reuses the existing AXI_ID_WIDTH.
- One sub-module, noc_idx_fifo: synchronous FIFO of MIDX_W-bit entries with depth MAX_OUTST. It exposes push, pop, head, full and empty, and takes ARESET asynchronously.
- The round-robin pick is a function inside s5_wr_arbiter.

## Test plan
- Lone request, single beat: m_awvalid=0001 at edge 0, S5_AWREADY=1 → aw_sel=0 and S5_AWVALID=1 in cycle 1. Then w_sel=0; W beat with wlast=1 → FIFO empty, m_wready=0.
- Round-robin fairness: all four masters request continuously, S5_AWREADY=1 → grant order 0,1,2,3,0. Each grant holds until its handshake.
- Grant hold under backpressure: S5_AWREADY=0 for 5 cycles while m_awvalid[2] stays high and m_awvalid[1] rises → aw_sel stays 2 until the handshake; master 1 is granted next.
- FIFO full with MAX_OUTST=4: 4 AW handshakes with W held off → 5th request not granted. One WLAST pop → 5th is granted 1 cycle later. Also check push and pop in the same cycle.
- W ordering: AWs granted to masters 3 then 1, each with 4-beat bursts; m_wvalid[1] asserted first → m_wready[1]=0 until master 3's WLAST completes.
- B routing: S5_BVALID=1, S5_BID=4'b1001 → m_bvalid=0100, S5_BREADY follows m_bready[2]. Assert ARESET mid-burst → all outputs 0 asynchronously and FIFO empty.
